// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the SRAM arbiter: FSM states, requester port indices
// and the "no owner" grant value.
package sram_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   localparam logic [1:0] PORT_VGA   = 2'd0;
   localparam logic [1:0] PORT_CAM   = 2'd1;
   localparam logic [1:0] PORT_UART  = 2'd2;
   localparam logic [1:0] GRANT_NONE = 2'd3;

   localparam logic [3:0] AGE_MAX = 4'd15;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner select: port 0 has fixed priority, ports 1/2 alternate.
// With SRAM_ARB_AGE_EN defined, a port 1/2 whose age reached 15 overrides port 0.
module sram_arb_pick
   import sram_arbiter_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] rr_last,
`ifdef SRAM_ARB_AGE_EN
   input  logic [3:0] age1,
   input  logic [3:0] age2,
`endif
   output logic [1:0] win,
   output logic       valid
);

   logic [1:0] rr_pick;

`ifdef SRAM_ARB_AGE_EN
   logic aged1;
   logic aged2;

   assign aged1 = req[1] && (age1 == AGE_MAX);
   assign aged2 = req[2] && (age2 == AGE_MAX);
`endif

   // The port not served last wins a camera/UART tie.
   always_comb begin
      rr_pick = PORT_CAM;
      if (req[1] && req[2]) begin
         rr_pick = (rr_last == PORT_CAM) ? PORT_UART : PORT_CAM;
      end else if (req[2]) begin
         rr_pick = PORT_UART;
      end
   end

   always_comb begin
      win   = GRANT_NONE;
      valid = |req;
      if (req[0]) begin
         win = PORT_VGA;
      end else if (|req[2:1]) begin
         win = rr_pick;
      end
`ifdef SRAM_ARB_AGE_EN
      if (aged1 && aged2) begin
         win = rr_pick;
      end else if (aged1) begin
         win = PORT_CAM;
      end else if (aged2) begin
         win = PORT_UART;
      end
`endif
   end

endmodule

// File: rtl/sram_arbiter.sv
// Three-way arbiter in front of ram_ctrl: serialises VGA/camera/UART requests,
// holds the command until workdone and aborts hung transactions. Optional ageing: SRAM_ARB_AGE_EN.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 20,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        req,
   input  logic [2:0]        we,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [ADDR_W-1:0] addr2,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [DATA_W-1:0] wdata2,
   output logic [2:0]        ack,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        grant_id
);

   // Last BUSY cycle index; the counter holds the number of BUSY cycles already elapsed.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   arb_state_t        state;
   arb_state_t        next_state;
   logic              we_l;
   logic              abort;
   logic [7:0]        cnt;
   logic [1:0]        rr_last;
   logic [1:0]        pick_idx;
   logic              pick_valid;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_we;

`ifdef SRAM_ARB_AGE_EN
   logic [3:0] age1;
   logic [3:0] age2;
`endif

   sram_arb_pick u_pick (
      .req     (req),
      .rr_last (rr_last),
`ifdef SRAM_ARB_AGE_EN
      .age1    (age1),
      .age2    (age2),
`endif
      .win     (pick_idx),
      .valid   (pick_valid)
   );

   always_comb begin
      sel_addr  = addr2;
      sel_wdata = wdata2;
      sel_we    = we[2];
      case (pick_idx)
         PORT_VGA: begin
            sel_addr  = addr0;
            sel_wdata = wdata0;
            sel_we    = we[0];
         end
         PORT_CAM: begin
            sel_addr  = addr1;
            sel_wdata = wdata1;
            sel_we    = we[1];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Command strobes decode straight from state so reset drops them at once.
   always_comb begin
      next_state = state;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ack        = 3'b000;
      err        = 1'b0;
      case (state)
         IDLE: begin
            if (pick_valid) next_state = BUSY;
         end
         BUSY: begin
            mem_read  = !we_l;
            mem_write = we_l;
            if (mem_done || (cnt == TO_LAST)) next_state = DONE;
         end
         DONE: begin
            ack        = 3'b001 << grant_id;
            err        = abort;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_id  <= GRANT_NONE;
         mem_addr  <= '0;
         mem_wdata <= '0;
         we_l      <= 1'b0;
         cnt       <= '0;
         abort     <= 1'b0;
         rdata     <= '0;
         rr_last   <= PORT_CAM;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant_id  <= pick_idx;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  we_l      <= sel_we;
                  cnt       <= '0;
                  abort     <= 1'b0;
               end
            end
            BUSY: begin
               if (mem_done) begin
                  if (!we_l) rdata <= mem_rdata;
               end else if (cnt == TO_LAST) begin
                  abort <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               grant_id <= GRANT_NONE;
               if (grant_id != PORT_VGA) rr_last <= grant_id;
            end
            default: ;
         endcase
      end
   end

`ifdef SRAM_ARB_AGE_EN
   // Ages count VGA grants a waiting port sat through; being served clears them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         age1 <= '0;
         age2 <= '0;
      end else if ((state == IDLE) && pick_valid) begin
         if (pick_idx == PORT_VGA) begin
            if (req[1] && (age1 != AGE_MAX)) age1 <= age1 + 4'd1;
            if (req[2] && (age2 != AGE_MAX)) age2 <= age2 + 4'd1;
         end
         if (pick_idx == PORT_CAM)  age1 <= '0;
         if (pick_idx == PORT_UART) age2 <= '0;
      end
   end
`endif

endmodule
